// File: rtl/uart_rx.sv
// uart_rx: UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) feeding a
// first-word-fall-through FIFO read through a valid/ready handshake.
module uart_rx #(
    parameter int CLK_PER_BIT = 104,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overflow,
    output logic       parity_err,
    output logic       busy
);
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t           state_r, state_nxt_s;
    logic             rxd_meta_r, rxd_sync_r;
    logic [1:0]       flush_r;
    logic             armed_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             cnt_clr_s, shift_en_s, push_s, frame_err_s;
    logic             frame_err_r, overflow_r;
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, count_s;
    logic             pop_s, full_s, write_s;

`ifdef UART_RX_PARITY_EN
    logic par_bit_r, par_cap_s, parity_err_s, parity_err_r;

    function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
        return ((^d) ^ p) == 1'b0;
    endfunction
`endif

    // Synchronizer; start detection is armed only once a genuine high has been seen after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            flush_r    <= 2'b00;
            armed_r    <= 1'b0;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
            flush_r    <= {flush_r[0], 1'b1};
            armed_r    <= armed_r | (flush_r[1] & rxd_sync_r);
        end
    end

    // Receiver state, bit timer and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            if (cnt_clr_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (shift_en_s) begin
                shift_r   <= {rxd_sync_r, shift_r[7:1]};
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

    // Next-state and per-sample actions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
        shift_en_s  = 1'b0;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap_s    = 1'b0;
        parity_err_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (armed_r && !rxd_sync_r) begin
                    state_nxt_s = ST_START;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = rxd_sync_r ? ST_IDLE : ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_clr_s  = 1'b1;
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_clr_s   = 1'b1;
                    par_cap_s   = 1'b1;
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_clr_s = 1'b1;
                    // A bad stop bit outranks a parity failure.
                    if (!rxd_sync_r) begin
                        frame_err_s = 1'b1;
                        state_nxt_s = ST_WAIT_HIGH;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (!even_parity_ok(shift_r, par_bit_r)) begin
                        parity_err_s = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end
`endif
                    else begin
                        push_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxd_sync_r) begin
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                cnt_clr_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign count_s = wr_ptr_r - rd_ptr_r;
    assign full_s  = (count_s == DEPTH_P);
    assign valid   = (count_s != {PTR_W{1'b0}});
    assign pop_s   = valid & ready;
    assign write_s = push_s & (~full_s | pop_s);

    // FIFO pointers and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            frame_err_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            frame_err_r <= frame_err_s;
            overflow_r  <= push_s & ~write_s;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (resetn && write_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit and its error pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            par_bit_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (par_cap_s) begin
                par_bit_r <= rxd_sync_r;
            end
            parity_err_r <= parity_err_s;
        end
    end
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = valid ? mem_r[rd_ptr_r[AW-1:0]] : 8'h00;
    assign frame_err = frame_err_r;
    assign overflow  = overflow_r;
    assign busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level timing model with a per-cycle output compare,
// plus literal checks on the received byte sequence and pulse counts.
module tb_uart_rx;
    localparam int CPB   = 104;
    localparam int DEPTH = 8;
    localparam int NCYC  = 40000;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overflow, parity_err, busy;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  n_ferr = 0, n_ovf = 0, n_perr = 0;
    bit  checking = 1'b0;

    bit         exp_busy [NCYC];
    bit         exp_push [NCYC];
    logic [7:0] exp_byte [NCYC];
    bit         exp_ferr [NCYC];
    bit         exp_perr [NCYC];
    bit         exp_ovf  [NCYC];
    logic [7:0] model_q [$];
    logic [7:0] got [$];
    logic [7:0] want [$];

    logic        e_valid;
    logic [7:0]  e_data;
    logic [12:0] e_vec, a_vec;

    uart_rx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .rxd(rxd), .data(data), .valid(valid),
        .ready(ready), .frame_err(frame_err), .overflow(overflow),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want_v);
        n_checks++;
        if (act !== want_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want_v);
        end
    endtask

    // Per-cycle compare against the model, then advance the model over the next edge.
    always @(negedge clk) begin
        if (checking && cyc < NCYC - 1) begin
            e_valid = (model_q.size() != 0);
            e_data  = e_valid ? model_q[0] : 8'h00;
            e_vec   = {e_valid, e_data, exp_busy[cyc], exp_ferr[cyc], exp_ovf[cyc], exp_perr[cyc]};
            a_vec   = {valid, data, busy, frame_err, overflow, parity_err};
            check($sformatf("cycle_%0d{valid,data,busy,ferr,ovf,perr}", cyc), 32'(a_vec), 32'(e_vec));
            if (valid && ready) got.push_back(data);
            if (frame_err) n_ferr++;
            if (overflow) n_ovf++;
            if (parity_err) n_perr++;
            if (!resetn) begin
                model_q.delete();
            end else begin
                if (e_valid && ready) model_q.delete(0);
                if (exp_push[cyc+1]) begin
                    if (model_q.size() < DEPTH) model_q.push_back(exp_byte[cyc+1]);
                    else exp_ovf[cyc+1] = 1'b1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame starting now; rst_bit >= 0 pulses resetn mid data bit rst_bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                              input int rst_bit, input int gap);
        int e, t, s, r, h;
        logic [NBITS-1:0] bits;
        bit par_good;
        e = cyc;
        t = e + 2;
        s = t + CPB / 2 + (NBITS - 1) * CPB;
        h = e + (NBITS - 1) * CPB + 2000;
`ifdef UART_RX_PARITY_EN
        bits     = {stop_ok, (^b) ^ par_flip, b, 1'b0};
        par_good = !par_flip;
`else
        bits     = {stop_ok, b, 1'b0};
        par_good = 1'b1;
`endif
        r = (rst_bit >= 0) ? e + (rst_bit + 1) * CPB + CPB / 2 : -1;
        for (int c = t + 1; c <= s; c++)
            if (r < 0 || c <= r) exp_busy[c] = 1'b1;
        if (r < 0) begin
            if (!stop_ok) begin
                exp_ferr[s+1] = 1'b1;
                for (int c = s + 1; c <= h + 2; c++) exp_busy[c] = 1'b1;
            end else if (!par_good) begin
                exp_perr[s+1] = 1'b1;
            end else begin
                exp_push[s+1] = 1'b1;
                exp_byte[s+1] = b;
            end
        end
        for (int k = 0; k < NBITS; k++) begin
            rxd = bits[k];
            for (int j = 0; j < CPB; j++) begin
                resetn = (cyc != r);
                @(posedge clk);
                #1;
            end
        end
        resetn = 1'b1;
        if (!stop_ok) begin
            idle(2000 - CPB);
            rxd = 1'b1;
        end
        idle(gap);
    endtask

    task automatic send_glitch(input int low_cycles, input int gap);
        int t;
        t = cyc + 2;
        for (int c = t + 1; c <= t + CPB / 2; c++) exp_busy[c] = 1'b1;
        rxd = 1'b0;
        idle(low_cycles);
        rxd = 1'b1;
        idle(gap);
    endtask

    initial begin
        #(NCYC * 10);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        rxd    = 1'b1;
        ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn   = 1'b1;
        checking = 1'b1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        idle(10);

        ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0, -1, 5);
        send_frame(8'hA3, 1'b1, 1'b0, -1, 5);
        send_glitch(40, 60);
        send_frame(8'h0F, 1'b1, 1'b0, -1, 5);
        send_frame(8'h81, 1'b0, 1'b0, -1, 20);
        send_frame(8'h42, 1'b1, 1'b0, -1, 5);

        ready = 1'b0;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0, -1, 3);
        check("overflow_count", 32'(n_ovf), 32'd1);
        ready = 1'b1;
        idle(12);
        ready = 1'b0;
        check("drained_valid", 32'(valid), 32'd0);

        for (int i = 0; i < 3; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, -1, 3);
        check("buffered_valid", 32'(valid), 32'd1);
        send_frame(8'h03, 1'b1, 1'b0, 4, 20);
        check("after_reset_valid", 32'(valid), 32'd0);
        ready = 1'b1;
        send_frame(8'hC6, 1'b1, 1'b0, -1, 10);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0, -1, 10);
        send_frame(8'h01, 1'b1, 1'b1, -1, 10);
`endif
        idle(5);

        want = '{8'h55, 8'hA3, 8'h0F, 8'h42, 8'h00, 8'h01, 8'h02, 8'h03,
                 8'h04, 8'h05, 8'h06, 8'h07, 8'hC6};
`ifdef UART_RX_PARITY_EN
        want.push_back(8'h01);
        check("parity_err_count", 32'(n_perr), 32'd1);
`else
        check("parity_err_count", 32'(n_perr), 32'd0);
`endif
        check("frame_err_count", 32'(n_ferr), 32'd1);
        check("overflow_total", 32'(n_ovf), 32'd1);
        check("rx_byte_count", 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++)
            check($sformatf("rx_byte_%0d", i), 32'(got[i]), 32'(want[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver with a small output FIFO: the inbound UART path that pairs with the HID report printer's transmitter on the board UART. It samples `UART_RXD` in the 12 MHz USB clock domain and frames 8N1 bytes. Bytes go into a first-word-fall-through FIFO behind a valid/ready handshake, so a downstream command decoder can consume them at its own pace.

## Interface
- `CLK_PER_BIT`, 104: clock cycles per bit (12 MHz / 115200); minimum 8.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, 2..64.
- `clk`  in  1  receiver clock (the 12 MHz USB clock); all logic is on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `rxd`  in  1  asynchronous serial input; idles high.
- `data`  out  8  FIFO head byte; valid only while `valid`=1.
- `valid`  out  1  FIFO not empty.
- `ready`  in  1  consumer accepts `data` when `valid && ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overflow`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.
- `busy`  out  1  high in every receiver state except IDLE.

## Operation
- Input path: 2-flop synchronizer. Both flops reset to 1, so the line reads idle.
- Bit-timing counter is `$clog2(CLK_PER_BIT)` bits wide. It clears on every state transition.
- IDLE: synced line = 0 → START.
- START: when the counter reaches `CLK_PER_BIT/2 - 1` (integer division), sample the line.
  - Line = 1 → IDLE (glitch rejected; no error).
  - Line = 0 → DATA.
- DATA: sample every `CLK_PER_BIT` cycles. Shift right into the shift register (LSB first). After 8 samples → PARITY if enabled, else STOP.
- PARITY (macro only): sample 1 bit. Even parity is required (XOR of the 8 data bits and the parity bit = 0).
- STOP: sample 1 bit.
  - Stop = 1, no parity error: push the byte → IDLE.
  - Stop = 1, parity error: drop the byte, pulse `parity_err` → IDLE.
  - Stop = 0: drop the byte, pulse `frame_err` → WAIT_HIGH. If parity also failed, `frame_err` takes priority and `parity_err` does not pulse.
- WAIT_HIGH: stay until the synced line = 1 (break or noise), then → IDLE.
- FIFO:
  - Read/write pointers are `$clog2(FIFO_DEPTH)+1` bits; wrap is natural.
  - `data` = mem[rd]; `valid` = (count != 0).
  - Pop on `valid && ready`.
  - Push succeeds if count < `FIFO_DEPTH`, or if count = `FIFO_DEPTH` and a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` pulses. Stored contents are unchanged.
  - Push and pop in the same cycle leave count unchanged.
- Reset (`resetn`=0 at a clock edge), including mid-byte:
  - State → IDLE, counter and shift register → 0, pointers → 0.
  - `valid`, `busy`, `frame_err`, `overflow`, `parity_err` → 0; `data` → 0 (memory reads as don't-care but is muxed to 0 when empty).
  - A partially received byte is discarded.
  - After reset, no frame starts until the synced line has been 1 and then 0.

## Timing
- Let T = first cycle the synchronized line reads 0 (2 cycles after the `rxd` edge).
- Start sample: T + `CLK_PER_BIT/2`.
- Data bit i (0..7) sample: T + `CLK_PER_BIT/2` + (i+1)·`CLK_PER_BIT`.
- Stop sample: T + `CLK_PER_BIT/2` + 9·`CLK_PER_BIT` (10·`CLK_PER_BIT` with parity).
- Push, and any error pulse, occurs on the cycle after the stop sample. `valid` rises that cycle if the FIFO was empty.
- Back-to-back frames: return to IDLE at mid-stop lets a start edge be detected from the next cycle on. Tolerance is ±4% baud mismatch.
- `busy` is high from T+1 until the cycle after the stop sample (or until WAIT_HIGH exits).

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present; the frame is 8E1.
  - Stop sample moves one bit later.
  - `parity_err` is live.
- Not defined:
  - 8N1 frame.
  - No PARITY state is generated.
  - `parity_err` is constant 0.

## Test plan
- Send 0x55, then 0xA3, at exactly `CLK_PER_BIT`=104 with `ready`=1 → `data`=0x55 then 0xA3, each with one `valid`&`ready` cycle, 1 cycle after its stop sample; no error pulses.
- Drive `rxd` low for 40 cycles, then high → no push, no error; `busy` falls at T+52; next valid frame 0x0F is received correctly.
- Send 0x81 with the stop bit driven 0 and the line held low for 2000 cycles, then a good 0x42 → one `frame_err` pulse; 0x81 dropped; FSM stays in WAIT_HIGH until the line is high; 0x42 received.
- With `ready`=0, send 9 bytes 0x00..0x08 (`FIFO_DEPTH`=8) → `overflow` pulses once, at byte 0x08. Then `ready`=1 pops 0x00..0x07 in order, and `valid` drops after 8 pops.
- Assert `resetn`=0 for 1 cycle during bit 4 of a frame, with 3 bytes buffered → `valid`=0, `busy`=0 next cycle; the remainder of the aborted frame produces no push or error; a following 0xC6 is received.
- With `UART_RX_PARITY_EN`, send 0x01 with parity bit 1 → pushed. Send 0x01 with parity bit 0 → one `parity_err` pulse, nothing pushed.
